// File: rtl/dds_wave_core.sv
// dds_wave_core: DDS waveform engine with a phase accumulator, four waveforms
// (sine from an external registered ROM, sawtooth, square, triangle) and
// amplitude scaling. Configuration comes in over a valid/ready handshake and is
// shadowed until a phase wrap, so waveform changes never tear mid-period.
// Optional build macro DDS_SYNC_OUT_EN adds a sync_out pulse that marks the
// first output sample after each accumulator wrap.
module dds_wave_core #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int AMP_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [1:0]              cfg_wave,
   input  logic [ACC_W-1:0]        cfg_fword,
   input  logic [ADDR_W-1:0]       cfg_poff,
   input  logic [ADDR_W-1:0]       cfg_duty,
   input  logic [AMP_W-1:0]        cfg_amp,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [DATA_W+AMP_W-1:0] wave_out,
   output logic                    wave_valid
`ifdef DDS_SYNC_OUT_EN
   ,
   output logic                    sync_out
`endif
);

   localparam int OUT_W = DATA_W + AMP_W;
   localparam logic [ADDR_W-1:0] DUTY_RST = ADDR_W'(1) << (ADDR_W - 1);
   localparam logic [AMP_W-1:0]  AMP_RST  = AMP_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;

   state_t              state;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W:0]      acc_sum;
   logic                wrap;
   logic                accept;
   logic                apply;
   logic [ADDR_W-1:0]   phase;

   logic [1:0]          wave_act, wave_sh;
   logic [ACC_W-1:0]    fword_act, fword_sh;
   logic [ADDR_W-1:0]   poff_act, poff_sh;
   logic [ADDR_W-1:0]   duty_act, duty_sh;
   logic [AMP_W-1:0]    amp_act, amp_sh;

   logic                vld_p1, vld_p2;
   logic [ADDR_W-1:0]   phase_p1, phase_p2;
   logic [1:0]          wave_p1, wave_p2;
   logic [ADDR_W-1:0]   duty_p1, duty_p2;
   logic [AMP_W-1:0]    amp_p1, amp_p2;
   logic [DATA_W-1:0]   sample_p2;

   // Selects the raw sample for one phase index; the triangle folds the upper
   // half of the period by inverting the doubled phase.
   function automatic logic [DATA_W-1:0] wave_sample(input logic [1:0]        wave,
                                                     input logic [ADDR_W-1:0] p,
                                                     input logic [ADDR_W-1:0] duty,
                                                     input logic [DATA_W-1:0] sine);
      logic [ADDR_W-1:0] dbl;
      logic [ADDR_W-1:0] tri_v;
      dbl   = {p[ADDR_W-2:0], 1'b0};
      tri_v = p[ADDR_W-1] ? ~dbl : dbl;
      case (wave)
         2'd0:    wave_sample = sine;
         2'd1:    wave_sample = p[ADDR_W-1 -: DATA_W];
         2'd2:    wave_sample = (p < duty) ? '1 : '0;
         default: wave_sample = tri_v[ADDR_W-1 -: DATA_W];
      endcase
   endfunction

   // Full-width unsigned amplitude scaling; the product always fits, so no clipping.
   function automatic logic [OUT_W-1:0] scale(input logic [DATA_W-1:0] s,
                                              input logic [AMP_W-1:0]  a);
      logic [OUT_W-1:0] s_w;
      logic [OUT_W-1:0] a_w;
      s_w   = OUT_W'(s);
      a_w   = OUT_W'(a);
      scale = s_w * a_w;
   endfunction

   assign acc_sum = {1'b0, acc} + {1'b0, fword_act};
   assign wrap    = en & acc_sum[ACC_W];
   assign phase   = acc[ACC_W-1 -: ADDR_W] + poff_act;
   assign accept  = cfg_valid & cfg_ready;
   // A stopped or frozen accumulator would never wrap, so apply at once then.
   assign apply   = (state == ARMED) & (wrap | ~en | (fword_act == '0));

   // Phase accumulator advances by the active tuning word while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_sum[ACC_W-1:0];
      end
   end

   // Config FSM: capture into shadow, then copy shadow to active when safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cfg_ready <= 1'b1;
         wave_sh   <= '0;
         fword_sh  <= '0;
         poff_sh   <= '0;
         duty_sh   <= '0;
         amp_sh    <= '0;
         wave_act  <= 2'd0;
         fword_act <= '0;
         poff_act  <= '0;
         duty_act  <= DUTY_RST;
         amp_act   <= AMP_RST;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (accept) begin
                  wave_sh   <= cfg_wave;
                  fword_sh  <= cfg_fword;
                  poff_sh   <= cfg_poff;
                  duty_sh   <= cfg_duty;
                  amp_sh    <= cfg_amp;
                  state     <= ARMED;
                  cfg_ready <= 1'b0;
               end else begin
                  state <= en ? RUN : IDLE;
               end
            end
            ARMED: begin
               if (apply) begin
                  wave_act  <= wave_sh;
                  fword_act <= fword_sh;
                  poff_act  <= poff_sh;
                  duty_act  <= duty_sh;
                  amp_act   <= amp_sh;
                  state     <= en ? RUN : IDLE;
                  cfg_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   // ---- S1: phase index to ROM, config captured alongside its sample ----
   // S1 control: ROM address and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         vld_p1   <= 1'b0;
      end else begin
         rom_addr <= phase;
         vld_p1   <= en;
      end
   end

   // S1/S2 data: config fields ride with the phase so ROM data lines up in S2.
   always_ff @(posedge clk) begin
      phase_p1 <= phase;
      wave_p1  <= wave_act;
      duty_p1  <= duty_act;
      amp_p1   <= amp_act;
      phase_p2 <= phase_p1;
      wave_p2  <= wave_p1;
      duty_p2  <= duty_p1;
      amp_p2   <= amp_p1;
   end

   // ---- S2: ROM data valid, waveform selection ----
   assign sample_p2 = wave_sample(wave_p2, phase_p2, duty_p2, rom_data);

   // S2 control valid, then S3 scaling; wave_out holds while no live sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2     <= 1'b0;
         wave_valid <= 1'b0;
         wave_out   <= '0;
      end else begin
         vld_p2     <= vld_p1;
         wave_valid <= vld_p2;
         // ---- S3: amplitude scaling ----
         if (vld_p2) begin
            wave_out <= scale(sample_p2, amp_p2);
         end
      end
   end

`ifdef DDS_SYNC_OUT_EN
   logic wrap_q, sync_p1, sync_p2;

   // Wrap flag first lines up with the post-wrap accumulator value, then
   // follows that sample through the three pipeline stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q   <= 1'b0;
         sync_p1  <= 1'b0;
         sync_p2  <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         wrap_q   <= wrap;
         sync_p1  <= wrap_q;
         sync_p2  <= sync_p1;
         sync_out <= sync_p2;
      end
   end
`endif

endmodule

// File: tb/tb_dds_wave_core.sv
// Directed bench for dds_wave_core: reset, sawtooth, square, triangle,
// deferred config update, immediate apply when stopped, reset while armed,
// and sine through a registered ROM model with phase offset.
module tb_dds_wave_core;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_wave;
   logic [31:0] cfg_fword;
   logic [8:0]  cfg_poff;
   logic [8:0]  cfg_duty;
   logic [3:0]  cfg_amp;
   logic [8:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [11:0] wave_out;
   logic        wave_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   dds_wave_core #(.ACC_W(32), .ADDR_W(9), .DATA_W(8), .AMP_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_wave   (cfg_wave),
      .cfg_fword  (cfg_fword),
      .cfg_poff   (cfg_poff),
      .cfg_duty   (cfg_duty),
      .cfg_amp    (cfg_amp),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .wave_out   (wave_out),
      .wave_valid (wave_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered sine ROM stand-in: one cycle of latency, easy-to-compute content.
   always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en        = 1'($urandom);
         cfg_valid = 1'($urandom);
         cfg_wave  = 2'($urandom);
         cfg_fword = $urandom;
         cfg_poff  = 9'($urandom);
         cfg_duty  = 9'($urandom);
         cfg_amp   = 4'($urandom);
         step();
         check("rst_wave_out", 32'(wave_out), 0);
         check("rst_wave_valid", 32'(wave_valid), 0);
         check("rst_cfg_ready", 32'(cfg_ready), 1);
         check("rst_rom_addr", 32'(rom_addr), 0);
      end
      en        = 1'b0;
      cfg_valid = 1'b0;
      rst_n     = 1'b1;
      step();
   endtask

   // Offer a config while stopped, confirm it applies at once, then raise en.
   // Leaves the bench at the negedge where en rose, with cyc = 2.
   task automatic cfg_and_start(input logic [1:0] w, input logic [31:0] f,
                                input logic [8:0] po, input logic [8:0] du,
                                input logic [3:0] am);
      cfg_valid = 1'b1;
      cfg_wave  = w;
      cfg_fword = f;
      cfg_poff  = po;
      cfg_duty  = du;
      cfg_amp   = am;
      step();
      check("cfg_ready_after_hs", 32'(cfg_ready), 0);
      cfg_valid = 1'b0;
      step();
      check("cfg_ready_2cyc", 32'(cfg_ready), 1);
      en  = 1'b1;
      cyc = 2;
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_wave  = 2'd0;
      cfg_fword = 32'd0;
      cfg_poff  = 9'd0;
      cfg_duty  = 9'd0;
      cfg_amp   = 4'd0;

      // Sawtooth, one index step per cycle
      do_reset();
      cfg_and_start(2'd1, 32'h0080_0000, 9'd0, 9'd256, 4'd1);
      check("saw_valid_start", 32'(wave_valid), 0);
      for (int k = 3; k <= 520; k++) begin
         step();
         check("saw_rom_addr", 32'(rom_addr), (k - 3) % 512);
         check("saw_valid", 32'(wave_valid), (k >= 5) ? 1 : 0);
         check("saw_out", 32'(wave_out), (k >= 5) ? ((k - 5) % 512) / 2 : 0);
      end

      // Square, duty 128 of 512, amplitude 15
      do_reset();
      cfg_and_start(2'd2, 32'h0080_0000, 9'd0, 9'd128, 4'd15);
      for (int k = 3; k <= 620; k++) begin
         step();
         if (k >= 5) check("square_out", 32'(wave_out), (((k - 5) % 512) < 128) ? 3825 : 0);
      end

      // Triangle at fixed points, then stop and confirm wave_out holds
      do_reset();
      cfg_and_start(2'd3, 32'h0080_0000, 9'd0, 9'd256, 4'd1);
      for (int k = 3; k <= 395; k++) begin
         step();
         case (k)
            5:   check("tri_p0", 32'(wave_out), 0);
            133: check("tri_p128", 32'(wave_out), 128);
            260: check("tri_p255", 32'(wave_out), 255);
            261: check("tri_p256", 32'(wave_out), 255);
            389: begin
               check("tri_p384", 32'(wave_out), 127);
               check("tri_valid_last", 32'(wave_valid), 1);
            end
            default: ;
         endcase
         if (k >= 390) begin
            check("hold_valid", 32'(wave_valid), 0);
            check("hold_out", 32'(wave_out), 127);
         end
         if (k == 387) en = 1'b0;
      end

      // Deferred update: amp 2 offered at p = 100, takes effect at the wrap
      do_reset();
      cfg_and_start(2'd1, 32'h0080_0000, 9'd0, 9'd256, 4'd1);
      for (int k = 3; k <= 530; k++) begin
         step();
         if (k >= 5) check("defer_out", 32'(wave_out), (((k - 5) % 512) / 2) * ((k >= 517) ? 2 : 1));
         check("defer_ready", 32'(cfg_ready), (k >= 103 && k < 514) ? 0 : 1);
         if (k == 102) begin
            cfg_valid = 1'b1;
            cfg_wave  = 2'd1;
            cfg_fword = 32'h0080_0000;
            cfg_poff  = 9'd0;
            cfg_duty  = 9'd256;
            cfg_amp   = 4'd2;
         end
         if (k == 103) cfg_valid = 1'b0;
         if (k == 200) begin
            cfg_valid = 1'b1;
            cfg_wave  = 2'd2;
            cfg_amp   = 4'd3;
         end
         if (k == 201) cfg_valid = 1'b0;
      end

      // Immediate apply while stopped (fword 2^24), then reset while armed
      do_reset();
      cfg_and_start(2'd1, 32'h0100_0000, 9'd0, 9'd256, 4'd1);
      step();
      check("fw24_addr0", 32'(rom_addr), 0);
      step();
      check("fw24_addr1", 32'(rom_addr), 2);
      step();
      check("fw24_addr2", 32'(rom_addr), 4);
      cfg_valid = 1'b1;
      cfg_wave  = 2'd2;
      cfg_fword = 32'h0080_0000;
      cfg_duty  = 9'd128;
      cfg_amp   = 4'd15;
      step();
      check("armed_ready", 32'(cfg_ready), 0);
      cfg_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("async_rst_ready", 32'(cfg_ready), 1);
      check("async_rst_valid", 32'(wave_valid), 0);
      check("async_rst_out", 32'(wave_out), 0);
      check("async_rst_addr", 32'(rom_addr), 0);
      step();
      rst_n = 1'b1;
      en    = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("post_rst_ready", 32'(cfg_ready), 1);
         check("post_rst_addr", 32'(rom_addr), 0);
         if (j >= 3) begin
            check("post_rst_valid", 32'(wave_valid), 1);
            check("post_rst_sine", 32'(wave_out), 165);
         end
      end

      // Sine from ROM with phase offset 10 and amplitude 3, accumulator frozen
      do_reset();
      cfg_and_start(2'd0, 32'd0, 9'd10, 9'd256, 4'd3);
      for (int k = 3; k <= 8; k++) begin
         step();
         check("sine_addr", 32'(rom_addr), 10);
         if (k >= 6) check("sine_out", 32'(wave_out), 525);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds_wave_core.md
Name: dds_wave_core

Overview:
Parametrised DDS waveform engine that generates the next generation of the panel-driven signal generator output.
- Replaces the fixed 9-bit address stepping with an ACC_W-bit phase accumulator and frequency tuning word.
- Adds a triangle wave and a programmable square duty cycle.
- Takes configuration through a valid/ready handshake; shadowed updates take effect only at a phase wrap, so changes are glitch-free.
- Sits between the front-panel control FSM (the config producer) and the DAC serialiser; the sine table stays an external registered ROM.

Parameters:
ACC_W, 32, phase accumulator width
ADDR_W, 9, phase index / ROM address width (must be >= DATA_W)
DATA_W, 8, unsigned sample width from ROM and generators
AMP_W, 4, unsigned amplitude multiplier width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  accumulator advances while high
cfg_valid  input  1  config word offered
cfg_ready  output  1  block can accept config
cfg_wave  input  2  0 sine, 1 sawtooth, 2 square, 3 triangle
cfg_fword  input  ACC_W  frequency tuning word
cfg_poff  input  ADDR_W  phase offset in index units
cfg_duty  input  ADDR_W  square high-threshold
cfg_amp  input  AMP_W  amplitude multiplier
rom_addr  output  ADDR_W  sine ROM address
rom_data  input  DATA_W  sine ROM data, 1-cycle registered latency
wave_out  output  DATA_W+AMP_W  scaled sample
wave_valid  output  1  wave_out carries a live sample

Behaviour:
- Reset values:
  - acc = 0; rom_addr = 0; wave_out = 0; wave_valid = 0; cfg_ready = 1.
  - Active config: wave 0, fword 0, poff 0, duty 2^(ADDR_W-1), amp 1.
  - Shadow config cleared; pending flag cleared.
- Accumulator: when en = 1, acc <= acc + fword_act, modulo 2^ACC_W. A wrap is the carry-out of that add. When en = 0, acc holds.
- Phase index: p = acc[ACC_W-1 -: ADDR_W] + poff_act, modulo 2^ADDR_W.
- Control FSM:
  - States: IDLE (en = 0, nothing pending), RUN (en = 1, nothing pending), ARMED (shadow pending).
  - IDLE/RUN accept a config when cfg_valid & cfg_ready. The config goes into shadow, the next state is ARMED, and cfg_ready = 0 from the next cycle.
  - ARMED: shadow is copied to active in the cycle where any of these holds: a wrap occurs, en = 0, or fword_act = 0.
  - After the copy: pending clears, the FSM returns to RUN or IDLE per en, and cfg_ready = 1 the following cycle.
  - A config accepted in the same cycle as a wrap is applied at the next wrap, not the current one.
  - cfg_* is ignored while cfg_ready = 0.
- Pipeline, fixed 3-cycle latency from accumulator value to wave_out:
  - S1: rom_addr <= p; register p, wave, duty and amp.
  - S2: rom_data valid; compute the selected sample from the S1 copies:
    - saw = p[ADDR_W-1 -: DATA_W]
    - square = (p < duty) ? all-ones : 0
    - triangle: t = p[ADDR_W-1] ? ~(p<<1) : (p<<1), truncated to ADDR_W; sample = t[ADDR_W-1 -: DATA_W]
  - S3: wave_out <= sample * amp, unsigned, full width, no saturation; amp = 0 gives 0.
- Config fields travel with their sample, so a change is visible on wave_out exactly 3 cycles after it becomes active.
- wave_valid = en delayed 3 cycles. wave_out holds its last value while wave_valid = 0.
- Reset asserted mid-operation immediately returns all state to reset values and discards any pending shadow.

Optional Feature:
DDS_SYNC_OUT_EN
- Defined: adds output sync_out (1 bit), reset 0. It is a one-cycle pulse aligned with wave_out for the first sample computed after each accumulator wrap, i.e. the wrap delayed 3 cycles.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n = 0 with random inputs -> wave_out = 0, wave_valid = 0, cfg_ready = 1, rom_addr = 0.
2. Config fword = 2^23, wave = 1, amp = 1, then raise en:
   - p increments by 1 per cycle.
   - wave_valid rises 3 cycles after en.
   - wave_out runs 0,0,1,1,2,... and reaches 255 at p = 511.
3. Wave = 2, duty = 128, amp = 15, fword = 2^23 -> wave_out = 3825 for 128 cycles, then 0 for 384 cycles, repeating with a 512-cycle period.
4. Wave = 3, amp = 1, fword = 2^23 -> wave_out = 0 / 128 / 255 / 255 / 127 at p = 0 / 128 / 255 / 256 / 384.
5. Deferred update, running saw with fword = 2^23, amp = 1:
   - At p = 100, offer amp = 2 -> cfg_ready = 0 next cycle; wave_out unchanged until the wrap 412 cycles later.
   - wave_out doubles 3 cycles after the wrap; cfg_ready = 1 the cycle after the wrap.
   - A second cfg_valid while cfg_ready = 0 is ignored.
6. Pending and reset:
   - With en = 0, offer fword = 2^24 -> applied at once; cfg_ready = 1 two cycles after the handshake.
   - Pulse rst_n while ARMED -> the config reverts to the reset defaults.
